// File: rtl/xm23_dev_pkg.sv
// Shared device-memory indices, CSR bit positions and timer FSM encoding
// for the xm23 device block.
package xm23_dev_pkg;

    localparam int KB_CSR   = 0;
    localparam int KB_DATA  = 1;
    localparam int SCR_CSR  = 2;
    localparam int SCR_DATA = 3;
    localparam int TMR_CSR  = 4;
    localparam int TMR_DATA = 5;

    localparam int CSR_IE   = 0;
    localparam int CSR_DBA  = 2;
    localparam int CSR_OF   = 3;
    localparam int CSR_ENA  = 4;
    localparam int CSR_MODE = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/xm23_timer_dev_if.sv
// CPU-side device-memory strobe bus into the timer.
interface xm23_timer_dev_if;
    logic       wr_en;
    logic       rd_en;
    logic       reg_sel;
    logic [7:0] wr_data;

    modport master (output wr_en, output rd_en, output reg_sel, output wr_data);
    modport slave  (input  wr_en, input  rd_en, input  reg_sel, input  wr_data);
endinterface

// File: rtl/tmr_prescaler.sv
// Tick generator: counts 0..PRESCALE-1 while run is high, pulses tick on the
// wrap cycle, and snaps back to 0 whenever run drops.
module tmr_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic run,
    output logic tick
);
    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = 16'd0;
        if (run && !tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(negedge Clock) begin
        if (!Reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/xm23_timer_dev.sv
// Programmable interval timer for device-memory slots TMR_CSR/TMR_DATA.
// Build option: define TMR_ONESHOT_EN to add the CSR MODE (one-shot) bit.
module xm23_timer_dev
    import xm23_dev_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter int CNT_W    = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    xm23_timer_dev_if.slave  bus,
    output logic [7:0]       csr_o,
    output logic [7:0]       data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             irq_o
);
    tmr_state_e       state_q, state_d;
    logic             ie_q, ie_d, ena_q, ena_d, mode_q, mode_d;
    logic             dba_q, dba_d, of_q, of_d, irq_q, irq_d;
    logic [CNT_W-1:0] period_q, period_d, count_q, count_d;
    logic             csr_wr, data_wr, ena_w, mode_w, run, tick, expiry;
    logic             unused_wr_bits;

    assign csr_wr  = bus.wr_en && !bus.reg_sel;
    assign data_wr = bus.wr_en && bus.reg_sel;
    assign ena_w   = csr_wr ? bus.wr_data[CSR_ENA] : ena_q;
`ifdef TMR_ONESHOT_EN
    assign mode_w  = csr_wr ? bus.wr_data[CSR_MODE] : mode_q;
`else
    assign mode_w  = 1'b0;
`endif
    assign unused_wr_bits = ^{bus.wr_data[7:5], bus.wr_data[3:1]};

    // Dropping ENA or writing the period in this cycle holds the prescaler at 0
    // and suppresses any tick, so a pending expiry is discarded.
    assign run = (state_q == RUN) && ena_w && !data_wr;

    tmr_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .run     (run),
        .tick    (tick)
    );

    always_comb begin
        ie_d     = ie_q;
        period_d = period_q;
        count_d  = count_q;
        dba_d    = dba_q;
        of_d     = of_q;
        expiry   = 1'b0;
        irq_d    = ie_q & dba_q;

        if (csr_wr) begin
            ie_d = bus.wr_data[CSR_IE];
        end

        if (data_wr) begin
            period_d = CNT_W'(bus.wr_data);
            count_d  = '0;
        end else if (tick) begin
            if (count_q == period_q - CNT_W'(1)) begin
                count_d = '0;
                expiry  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end

        // Read-clear lands before the expiry so a coincident event survives.
        if (bus.rd_en) begin
            dba_d = 1'b0;
            of_d  = 1'b0;
        end
        if (expiry) begin
            of_d  = of_d | dba_d;
            dba_d = 1'b1;
        end

        mode_d  = mode_w;
        ena_d   = ena_w && !(expiry && mode_w);
        state_d = (ena_d && (period_d != '0)) ? RUN : IDLE;
    end

    always_ff @(negedge Clock) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ie_q     <= 1'b0;
            ena_q    <= 1'b0;
            mode_q   <= 1'b0;
            dba_q    <= 1'b0;
            of_q     <= 1'b0;
            irq_q    <= 1'b0;
            period_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            ie_q     <= ie_d;
            ena_q    <= ena_d;
            mode_q   <= mode_d;
            dba_q    <= dba_d;
            of_q     <= of_d;
            irq_q    <= irq_d;
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        csr_o           = 8'h00;
        csr_o[CSR_IE]   = ie_q;
        csr_o[CSR_DBA]  = dba_q;
        csr_o[CSR_OF]   = of_q;
        csr_o[CSR_ENA]  = ena_q;
        csr_o[CSR_MODE] = mode_q;
    end

    assign data_o  = 8'(period_q);
    assign count_o = count_q;
    assign irq_o   = irq_q;
endmodule

// File: tb/tb_xm23_timer_dev.sv
// Self-checking bench for xm23_timer_dev with PRESCALE = 4 against a
// behavioural model of the timer rules.
module tb_xm23_timer_dev;
    localparam int PRESC = 4;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic [7:0] csr_o, data_o, count_o;
    logic       irq_o;
    int         total = 0;
    int         bad   = 0;

    xm23_timer_dev_if bus();

    xm23_timer_dev #(.PRESCALE(PRESC), .CNT_W(8)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus),
        .csr_o   (csr_o),
        .data_o  (data_o),
        .count_o (count_o),
        .irq_o   (irq_o)
    );

    always #5 Clock = ~Clock;

    // model state
    logic       m_ie, m_ena, m_mode, m_dba, m_of, m_irq, m_running;
    logic [7:0] m_period, m_count;
    int         m_presc;

    function automatic logic [7:0] exp_csr();
        return {2'b00, m_mode, m_ena, m_of, m_dba, 1'b0, m_ie};
    endfunction

    task automatic model_step(input logic rst_n, input logic wr, input logic rd,
                              input logic sel, input logic [7:0] d);
        logic n_ena, n_mode, expire;
        if (!rst_n) begin
            {m_ie, m_ena, m_mode, m_dba, m_of, m_irq, m_running} = '0;
            m_period = 8'd0;
            m_count  = 8'd0;
            m_presc  = 0;
        end else begin
            m_irq  = m_ie & m_dba;
            n_ena  = m_ena;
            n_mode = m_mode;
            expire = 1'b0;
            if (wr && !sel) begin
                m_ie  = d[0];
                n_ena = d[4];
`ifdef TMR_ONESHOT_EN
                n_mode = d[5];
`endif
            end
            if (wr && sel) begin
                m_period = d;
                m_count  = 8'd0;
                m_presc  = 0;
            end else if (m_running && n_ena) begin
                if (m_presc == PRESC - 1) begin
                    m_presc = 0;
                    if (int'(m_count) + 1 == int'(m_period)) begin
                        m_count = 8'd0;
                        expire  = 1'b1;
                    end else begin
                        m_count = m_count + 8'd1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end else begin
                m_presc = 0;
            end
            if (rd) begin
                m_dba = 1'b0;
                m_of  = 1'b0;
            end
            if (expire) begin
                m_of  = m_of | m_dba;
                m_dba = 1'b1;
                if (n_mode) n_ena = 1'b0;
            end
            m_ena     = n_ena;
            m_mode    = n_mode;
            m_running = m_ena && (m_period != 8'd0);
        end
    endtask

    task automatic cycle(input logic rst_n, input logic wr, input logic rd,
                         input logic sel, input logic [7:0] d);
        Reset_n     = rst_n;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.reg_sel = sel;
        bus.wr_data = d;
        @(negedge Clock);
        model_step(rst_n, wr, rd, sel, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
        total++; if (csr_o !== 8'h00) begin bad++; $display("FAIL reset_csr got=%h exp=00", csr_o); end
        total++; if (data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_o); end
        total++; if (count_o !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=00", count_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_periodic();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
        total++; if (data_o !== 8'h03) begin bad++; $display("FAIL per_data got=%h exp=03", data_o); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        total++; if (csr_o !== 8'h11) begin bad++; $display("FAIL per_csr_wr got=%h exp=11", csr_o); end
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            total++;
            if (count_o !== m_count) begin
                bad++; $display("FAIL per_count cyc=%0d got=%h exp=%h", i, count_o, m_count);
            end
            if (i == 4 || i == 8) begin
                total++;
                if (count_o !== 8'(i / 4)) begin
                    bad++; $display("FAIL per_step cyc=%0d got=%h exp=%h", i, count_o, 8'(i / 4));
                end
            end
            if (i == 11) begin
                total++; if (csr_o[2] !== 1'b0) begin bad++; $display("FAIL per_early_dba got=%b exp=0", csr_o[2]); end
            end
        end
        total++; if (csr_o !== 8'h15) begin bad++; $display("FAIL per_expire_csr got=%h exp=15", csr_o); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL per_irq_early got=%b exp=0", irq_o); end
        idle(1);
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL per_irq got=%b exp=1", irq_o); end
    endtask

    task automatic test_overrun();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h02);
        idle(16);
        total++; if (csr_o !== 8'h1D) begin bad++; $display("FAIL ovr_csr got=%h exp=1D", csr_o); end
        total++; if (csr_o !== exp_csr()) begin bad++; $display("FAIL ovr_model got=%h exp=%h", csr_o, exp_csr()); end
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (csr_o !== 8'h11) begin bad++; $display("FAIL ovr_read_csr got=%h exp=11", csr_o); end
        idle(1);
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL ovr_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_read_expiry();
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_running && m_presc == PRESC - 1 && int'(m_count) + 1 == int'(m_period)) begin
                cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        total++; if (!found) begin bad++; $display("FAIL rdexp_timeout got=0 exp=1"); end
        total++; if (csr_o !== 8'h15) begin bad++; $display("FAIL rdexp_csr got=%h exp=15", csr_o); end
    endtask

    task automatic test_period0_ena_drop();
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            total++; if (count_o !== 8'h00) begin bad++; $display("FAIL p0_count cyc=%0d got=%h exp=00", i, count_o); end
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
        idle(8);
        total++; if (count_o !== 8'h02) begin bad++; $display("FAIL drop_pre got=%h exp=02", count_o); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        idle(10);
        total++; if (count_o !== 8'h02) begin bad++; $display("FAIL drop_hold got=%h exp=02", count_o); end
        total++; if (csr_o[4] !== 1'b0) begin bad++; $display("FAIL drop_ena got=%b exp=0", csr_o[4]); end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
        idle(3);
        total++; if (count_o !== 8'h02) begin bad++; $display("FAIL drop_presc_reset got=%h exp=02", count_o); end
        idle(1);
        total++; if (count_o !== 8'h00) begin bad++; $display("FAIL drop_resume got=%h exp=00", count_o); end
    endtask

    task automatic test_mode();
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h31);
`ifdef TMR_ONESHOT_EN
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
        idle(3);
        total++; if (csr_o[2] !== 1'b0) begin bad++; $display("FAIL os_early got=%b exp=0", csr_o[2]); end
        idle(1);
        total++; if (csr_o !== 8'h25) begin bad++; $display("FAIL os_csr got=%h exp=25", csr_o); end
        for (int i = 0; i < 40; i++) begin
            idle(1);
            total++;
            if (csr_o !== 8'h25 || count_o !== 8'h00) begin
                bad++; $display("FAIL os_quiet cyc=%0d got=%h/%h exp=25/00", i, csr_o, count_o);
            end
        end
`else
        total++; if (csr_o !== 8'h11) begin bad++; $display("FAIL mode_ignored got=%h exp=11", csr_o); end
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h01);
        idle(8);
        total++; if (csr_o !== 8'h1D) begin bad++; $display("FAIL periodic_p1 got=%h exp=1D", csr_o); end
`endif
    endtask

    task automatic test_random();
        logic       r_rst, r_wr, r_rd, r_sel;
        logic [7:0] r_d;
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 63) != 0);
            r_wr  = ($urandom_range(0, 5) == 0);
            r_rd  = ($urandom_range(0, 7) == 0);
            r_sel = 1'($urandom_range(0, 1));
            r_d   = 8'($urandom);
            if (r_sel && $urandom_range(0, 3) != 0) r_d = 8'($urandom_range(0, 5));
            if (!r_sel && $urandom_range(0, 3) != 0) r_d[4] = 1'b1;
            cycle(r_rst, r_wr, r_rd, r_sel, r_d);
            total++;
            if (csr_o !== exp_csr() || data_o !== m_period || count_o !== m_count || irq_o !== m_irq) begin
                bad++;
                $display("FAIL rand cyc=%0d got csr=%h data=%h cnt=%h irq=%b exp csr=%h data=%h cnt=%h irq=%b",
                         i, csr_o, data_o, count_o, irq_o, exp_csr(), m_period, m_count, m_irq);
            end
        end
    endtask

    initial begin
        Reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.reg_sel = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_periodic();
        test_overrun();
        test_read_expiry();
        test_period0_ena_drop();
        test_mode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xm23_timer_dev.md
Name: xm23_timer_dev

Overview:
- Programmable interval timer occupying the device-memory timer slots: CSR at index 4, DATA at index 5.
- Sits beside the keyboard/screen driver. It is the producer of the CPU's timer CSR and DATA bytes, and the source of the timer interrupt request.
- It is updated through the same negedge bus path the CPU uses for device-memory access.

Parameters:
- PRESCALE, 50, Clock cycles per timer tick. Legal range 1..65535.
- CNT_W, 8, width of count and period registers.

Ports:
- Clock  input  1  system clock; all state changes on the negedge, matching the CPU device-memory update.
- Reset_n  input  1  synchronous, active-low reset, sampled on the active Clock edge.
- wr_en  input  1  one-cycle write strobe from the CPU data bus.
- rd_en  input  1  one-cycle read strobe (CPU MDR load from device memory).
- reg_sel  input  1  0 = CSR, 1 = DATA (period).
- wr_data  input  8  write data (MDR low byte).
- csr_o  output  8  CSR image for dev_mem[tmr_csr].
- data_o  output  8  period image for dev_mem[tmr_data].
- count_o  output  CNT_W  current count (debug/HEX display).
- irq_o  output  1  interrupt request to the interrupt controller.

Behaviour:
- CSR bit map:
  - bit0 IE, R/W.
  - bit2 DBA (expired), R, clear-on-read.
  - bit3 OF (overrun), R, clear-on-read.
  - bit4 ENA, R/W.
  - All other bits read 0.
- Reset (Reset_n = 0 at an active edge): csr_o = 0, data_o = 0, count_o = 0, prescaler = 0, irq_o = 0, FSM = IDLE.
- All outputs are registered. A write is visible on csr_o/data_o at the following active edge (latency 1).
- FSM states:
  - IDLE: ENA = 0 or period = 0. Count holds, prescaler held at 0.
  - RUN: prescaler counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and issues a tick.
  - IDLE -> RUN when ENA = 1 and period != 0. RUN -> IDLE when either condition drops.
- Tick in RUN:
  - If count == period-1: count <= 0, expiry event. Otherwise count <= count+1.
  - Count and period are unsigned CNT_W. A period of 1 expires every tick.
- Expiry event: if DBA is already 1, set OF; set DBA <= 1.
- CSR write: updates IE and ENA only; DBA and OF bits in wr_data are ignored. Clearing ENA holds count and resets the prescaler.
- DATA write: period <= wr_data, count <= 0, prescaler <= 0. A pending expiry in the same cycle is discarded.
- Read (rd_en, either reg_sel): clears DBA and OF.
  - Simultaneous read and expiry: the clear is applied first, then the event, so DBA = 1, OF = 0.
- Simultaneous wr_en and rd_en: the write is applied and the clear is applied.
- irq_o <= IE & DBA, registered. It deasserts on the edge after DBA is cleared or IE is cleared.
- Reset mid-count returns all state to reset values regardless of strobes.

Optional Feature:
- Macro TMR_ONESHOT_EN.
- Defined: CSR bit5 MODE is R/W. When MODE = 1, an expiry event also clears ENA in the same edge, so the FSM returns to IDLE with count = 0.
- Undefined: bit5 reads 0, writes to it are ignored, and the timer is always periodic.

Decomposition:
- Package xm23_dev_pkg holds:
  - Device indices KB_CSR = 0, KB_DATA = 1, SCR_CSR = 2, SCR_DATA = 3, TMR_CSR = 4, TMR_DATA = 5.
  - CSR bit positions IE = 0, DBA = 2, OF = 3, ENA = 4, MODE = 5.
  - FSM state encoding {IDLE, RUN}.
- One sub-module, tmr_prescaler: parameter PRESCALE; inputs Clock, Reset_n, run; output tick pulse.

Test Plan (PRESCALE = 4):
- Reset: hold Reset_n = 0 for 2 cycles with wr_en = 1 -> csr_o = 00, data_o = 00, count_o = 0, irq_o = 0.
- Periodic expiry and interrupt:
  - Stimulus: write DATA = 03, then CSR = 11 (IE + ENA).
  - Response: the count steps 0 -> 1 -> 2 -> 0 every 4 cycles. DBA sets on the 12th cycle after ENA, csr_o = 15, and irq_o = 1 one edge later.
- Overrun: with period = 02, leave the timer unread for two expiries -> csr_o = 1D (OF set). A read then gives csr_o = 11 and irq_o = 0 on the next edge.
- Read coincident with expiry: assert rd_en on the expiry cycle -> DBA = 1, OF = 0, csr_o = 15.
- Period 0 and ENA drop:
  - DATA = 00 with ENA = 1 -> FSM stays IDLE and count_o stays 0.
  - With a running count of 2, CSR = 01 -> count_o holds 2 and the prescaler resets.
- TMR_ONESHOT_EN:
  - Stimulus: CSR = 31, DATA = 01.
  - Response: one expiry, then csr_o = 25 (ENA cleared, DBA set). No further events over 40 cycles.
